// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - engine command buses, grants and SDRAM pins around the arbiter
interface sdram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int BA_W   = 2
);
    logic [3:0]        init_cmd;
    logic [BA_W-1:0]   init_ba;
    logic [ADDR_W-1:0] init_addr;
    logic              init_end;

    logic              aref_req;
    logic              aref_end;
    logic [3:0]        aref_cmd;
    logic [BA_W-1:0]   aref_ba;
    logic [ADDR_W-1:0] aref_addr;

    logic              wr_req;
    logic              wr_end;
    logic [3:0]        wr_cmd;
    logic [BA_W-1:0]   wr_ba;
    logic [ADDR_W-1:0] wr_addr;

    logic              rd_req;
    logic              rd_end;
    logic [3:0]        rd_cmd;
    logic [BA_W-1:0]   rd_ba;
    logic [ADDR_W-1:0] rd_addr;

    logic              sr_req;
    logic              sr_cke;
    logic [3:0]        sr_cmd;
    logic [BA_W-1:0]   sr_ba;
    logic [ADDR_W-1:0] sr_addr;
    logic              sr_done;

    logic              sdram_init;
    logic              aref_en;
    logic              wr_en;
    logic              rd_en;
    logic              self_ref_en;
    logic              sdram_cke;
    logic [3:0]        sdram_cmd;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;

    modport master (
        output init_cmd, init_ba, init_addr, init_end,
        output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        output wr_req, wr_end, wr_cmd, wr_ba, wr_addr,
        output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        output sr_req, sr_cke, sr_cmd, sr_ba, sr_addr, sr_done,
        input  sdram_init, aref_en, wr_en, rd_en, self_ref_en,
        input  sdram_cke, sdram_cmd, sdram_ba, sdram_addr
    );

    modport slave (
        input  init_cmd, init_ba, init_addr, init_end,
        input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr,
        input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        input  sr_req, sr_cke, sr_cmd, sr_ba, sr_addr, sr_done,
        output sdram_init, aref_en, wr_en, rd_en, self_ref_en,
        output sdram_cke, sdram_cmd, sdram_ba, sdram_addr
    );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - SDRAM engine arbiter and registered pin driver; SDRAM_ARB_FAIR_EN alternates write/read
module sdram_arbiter #(
    parameter int         ADDR_W  = 12,
    parameter int         BA_W    = 2,
    parameter logic [3:0] CMD_NOP = 4'b0111
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    sdram_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, ARBIT, AREF, WRITE, READ, SELF_REF
    } state_t;

    state_t state;
    state_t arb_next;
    logic   first_cycle;
`ifdef SDRAM_ARB_FAIR_EN
    logic   last_was_wr;
`endif

    always_comb begin
        arb_next = ARBIT;
        if (bus.sr_req)
            arb_next = SELF_REF;
        else if (bus.aref_req)
            arb_next = AREF;
        else if (bus.wr_req && bus.rd_req)
`ifdef SDRAM_ARB_FAIR_EN
            arb_next = last_was_wr ? READ : WRITE;
`else
            arb_next = WRITE;
`endif
        else if (bus.wr_req)
            arb_next = WRITE;
        else if (bus.rd_req)
            arb_next = READ;
    end

    assign bus.aref_en     = (state == AREF);
    assign bus.wr_en       = (state == WRITE);
    assign bus.rd_en       = (state == READ);
    // first_cycle keeps the grant up for one cycle even if sr_req drops on the grant edge
    assign bus.self_ref_en = (state == SELF_REF) && (bus.sr_req || first_cycle);

    // Pins are always captured from the bus selected by the current state,
    // so cke and cmd share the same single-cycle latency.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= IDLE;
            bus.sdram_init <= 1'b0;
            first_cycle    <= 1'b0;
`ifdef SDRAM_ARB_FAIR_EN
            last_was_wr    <= 1'b0;
`endif
            bus.sdram_cke  <= 1'b1;
            bus.sdram_cmd  <= CMD_NOP;
            bus.sdram_ba   <= {BA_W{1'b1}};
            bus.sdram_addr <= {ADDR_W{1'b1}};
        end else begin
            bus.sdram_cke  <= 1'b1;
            bus.sdram_cmd  <= CMD_NOP;
            bus.sdram_ba   <= {BA_W{1'b1}};
            bus.sdram_addr <= {ADDR_W{1'b1}};
            case (state)
                IDLE: begin
                    bus.sdram_cmd  <= bus.init_cmd;
                    bus.sdram_ba   <= bus.init_ba;
                    bus.sdram_addr <= bus.init_addr;
                    if (bus.init_end) begin
                        state          <= ARBIT;
                        bus.sdram_init <= 1'b1;
                    end
                end
                ARBIT: begin
                    state       <= arb_next;
                    first_cycle <= (arb_next == SELF_REF);
`ifdef SDRAM_ARB_FAIR_EN
                    if (arb_next == WRITE)
                        last_was_wr <= 1'b1;
                    else if (arb_next == READ)
                        last_was_wr <= 1'b0;
`endif
                end
                AREF: begin
                    bus.sdram_cmd  <= bus.aref_cmd;
                    bus.sdram_ba   <= bus.aref_ba;
                    bus.sdram_addr <= bus.aref_addr;
                    if (bus.aref_end)
                        state <= ARBIT;
                end
                WRITE: begin
                    bus.sdram_cmd  <= bus.wr_cmd;
                    bus.sdram_ba   <= bus.wr_ba;
                    bus.sdram_addr <= bus.wr_addr;
                    if (bus.wr_end)
                        state <= ARBIT;
                end
                READ: begin
                    bus.sdram_cmd  <= bus.rd_cmd;
                    bus.sdram_ba   <= bus.rd_ba;
                    bus.sdram_addr <= bus.rd_addr;
                    if (bus.rd_end)
                        state <= ARBIT;
                end
                SELF_REF: begin
                    first_cycle    <= 1'b0;
                    bus.sdram_cke  <= bus.sr_cke;
                    bus.sdram_cmd  <= bus.sr_cmd;
                    bus.sdram_ba   <= bus.sr_ba;
                    bus.sdram_addr <= bus.sr_addr;
                    if (bus.sr_done)
                        state <= ARBIT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed self-checking bench for sdram_arbiter
module tb_sdram_arbiter;
    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic exp_wr;

    sdram_arbiter_if #(.ADDR_W(12), .BA_W(2)) bus ();

    sdram_arbiter dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_grants(input string tag, input logic [3:0] exp);
        chk(tag, {bus.self_ref_en, bus.aref_en, bus.wr_en, bus.rd_en}, {28'd0, exp});
    endtask

    initial begin
        bus.init_cmd = 4'b0111; bus.init_ba = 2'b00; bus.init_addr = 12'h000; bus.init_end = 1'b0;
        bus.aref_req = 1'b0; bus.aref_end = 1'b0; bus.aref_cmd = 4'b0001; bus.aref_ba = 2'b01; bus.aref_addr = 12'h111;
        bus.wr_req = 1'b0; bus.wr_end = 1'b0; bus.wr_cmd = 4'b0100; bus.wr_ba = 2'b10; bus.wr_addr = 12'h222;
        bus.rd_req = 1'b0; bus.rd_end = 1'b0; bus.rd_cmd = 4'b0101; bus.rd_ba = 2'b00; bus.rd_addr = 12'h333;
        bus.sr_req = 1'b0; bus.sr_cke = 1'b1; bus.sr_cmd = 4'b0111; bus.sr_ba = 2'b00; bus.sr_addr = 12'h000;
        bus.sr_done = 1'b0;

        // reset state
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rst_cke", bus.sdram_cke, 1);
        chk("rst_cmd", bus.sdram_cmd, 4'b0111);
        chk("rst_ba", bus.sdram_ba, 2'b11);
        chk("rst_addr", bus.sdram_addr, 12'hfff);
        chk("rst_init", bus.sdram_init, 0);
        chk_grants("rst_grants", 4'b0000);
        tick();
        sys_rst_n = 1'b1;

        // init sequence
        bus.init_cmd = 4'b0010; bus.init_addr = 12'h400;
        tick();
        chk("init_cmd", bus.sdram_cmd, 4'b0010);
        chk("init_addr", bus.sdram_addr, 12'h400);
        chk("init_flag_pre", bus.sdram_init, 0);
        bus.init_cmd = 4'b0111; bus.init_addr = 12'h000; bus.init_end = 1'b1;
        tick();
        bus.init_end = 1'b0;
        chk("init_flag", bus.sdram_init, 1);
        tick();
        chk("arbit_cmd", bus.sdram_cmd, 4'b0111);
        chk("arbit_ba", bus.sdram_ba, 2'b11);
        chk("arbit_addr", bus.sdram_addr, 12'hfff);
        chk_grants("arbit_grants", 4'b0000);

        // priority aref > wr > rd with NOP gap between grants
        bus.aref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        tick();
        chk_grants("aref_grant", 4'b0100);
        chk("aref_gap_cmd", bus.sdram_cmd, 4'b0111);
        tick();
        chk("aref_cmd", bus.sdram_cmd, 4'b0001);
        chk("aref_addr", bus.sdram_addr, 12'h111);
        bus.aref_end = 1'b1; bus.aref_req = 1'b0;
        tick();
        bus.aref_end = 1'b0;
        chk_grants("aref_to_arbit", 4'b0000);
        tick();
        chk_grants("wr_grant", 4'b0010);
        chk("wr_gap_cmd", bus.sdram_cmd, 4'b0111);
        bus.rd_end = 1'b1;
        tick();
        bus.rd_end = 1'b0;
        chk("wr_cmd", bus.sdram_cmd, 4'b0100);
        chk("wr_ba", bus.sdram_ba, 2'b10);
        chk_grants("wr_ignores_rd_end", 4'b0010);
        bus.wr_end = 1'b1; bus.wr_req = 1'b0;
        tick();
        bus.wr_end = 1'b0;
        chk_grants("wr_to_arbit", 4'b0000);
        tick();
        chk_grants("rd_grant", 4'b0001);
        tick();
        chk("rd_cmd", bus.sdram_cmd, 4'b0101);
        chk("rd_addr", bus.sdram_addr, 12'h333);
        bus.rd_end = 1'b1; bus.rd_req = 1'b0;
        tick();
        bus.rd_end = 1'b0;
        chk_grants("rd_to_arbit", 4'b0000);

        // self-refresh beats aref; cke follows engine one cycle later
        bus.sr_req = 1'b1; bus.aref_req = 1'b1; bus.sr_cke = 1'b0; bus.sr_cmd = 4'b0001;
        tick();
        chk_grants("sr_grant", 4'b1000);
        chk("sr_cke_lat", bus.sdram_cke, 1);
        tick();
        chk("sr_cke", bus.sdram_cke, 0);
        chk("sr_cmd", bus.sdram_cmd, 4'b0001);
        bus.sr_req = 1'b0;
        #1;
        chk_grants("sr_drop", 4'b0000);
        tick();
        chk("sr_hold_cke", bus.sdram_cke, 0);
        chk_grants("sr_hold", 4'b0000);
        bus.sr_done = 1'b1; bus.sr_cke = 1'b1; bus.sr_cmd = 4'b0111; bus.aref_req = 1'b0;
        tick();
        bus.sr_done = 1'b0;
        chk_grants("sr_exit", 4'b0000);
        tick();
        chk("sr_exit_cke", bus.sdram_cke, 1);
        chk("sr_exit_cmd", bus.sdram_cmd, 4'b0111);

        // one-cycle sr_req still yields a grant and holds until sr_done
        bus.sr_req = 1'b1; bus.sr_cke = 1'b0; bus.sr_cmd = 4'b0001;
        tick();
        bus.sr_req = 1'b0;
        #1;
        chk("sr_first_cycle", bus.self_ref_en, 1);
        tick();
        chk("sr_first_cycle_end", bus.self_ref_en, 0);
        tick();
        tick();
        chk("sr_wait_cmd", bus.sdram_cmd, 4'b0001);
        chk("sr_wait_cke", bus.sdram_cke, 0);
        bus.sr_done = 1'b1; bus.sr_cke = 1'b1; bus.sr_cmd = 4'b0111;
        tick();
        bus.sr_done = 1'b0;

        // write/read contention
        bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            tick();
`ifdef SDRAM_ARB_FAIR_EN
            exp_wr = (g % 2 == 0);
`else
            exp_wr = 1'b1;
`endif
            chk($sformatf("contend_wr%0d", g), bus.wr_en, exp_wr);
            chk($sformatf("contend_rd%0d", g), bus.rd_en, !exp_wr);
            if (exp_wr) bus.wr_end = 1'b1;
            else        bus.rd_end = 1'b1;
            tick();
            bus.wr_end = 1'b0; bus.rd_end = 1'b0;
            chk_grants($sformatf("contend_gap%0d", g), 4'b0000);
        end

        // reset mid-write
        bus.rd_req = 1'b0;
        tick();
        chk("pre_rst_wr", bus.wr_en, 1);
        tick();
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd", bus.sdram_cmd, 4'b0111);
        chk("mid_rst_cke", bus.sdram_cke, 1);
        chk("mid_rst_wr_en", bus.wr_en, 0);
        chk("mid_rst_init", bus.sdram_init, 0);
        tick();
        sys_rst_n = 1'b1;
        bus.wr_req = 1'b0;
        tick();
        chk("post_rst_init", bus.sdram_init, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
